// File: rtl/interp_pkg.sv
// interp_pkg: shared state encoding and default widths for the interpolation scheduler.
package interp_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
  localparam int W_DEF = 16;
  localparam int OUT_W_DEF = 20;
  localparam int LOG2L_DEF = 2;
endpackage

// File: rtl/interp_lerp.sv
// interp_lerp: combinational linear interpolation y = prev + floor((cur-prev)*k / 2^LOG2L).
module interp_lerp #(
  parameter int W = 16,
  parameter int LOG2L = 2
) (
  input  logic [W-1:0]     i_prev,
  input  logic [W-1:0]     i_cur,
  input  logic [LOG2L-1:0] i_k,
  output logic [W-1:0]     o_y
);
  localparam int P = W + 1 + LOG2L;
  logic signed [P-1:0] w_pe, w_d, w_k, w_q;
  assign w_pe = {{(LOG2L+1){i_prev[W-1]}}, i_prev};
  assign w_d = {{(LOG2L+1){i_cur[W-1]}}, i_cur} - w_pe;
  assign w_k = {{(W+1){1'b0}}, i_k};
  assign w_q = (w_d * w_k) >>> LOG2L;
  // The result always lies between prev and cur, so truncation to W bits is exact.
  assign o_y = W'(w_pe + w_q);
endmodule

// File: rtl/interp_scheduler.sv
// interp_scheduler: issues L output words per input sample with a one-deep pending buffer.
// Define INTERP_LINEAR_EN for linear interpolation; otherwise zero-order hold.
module interp_scheduler
  import interp_pkg::*;
#(
  parameter int W = W_DEF,
  parameter int OUT_W = OUT_W_DEF,
  parameter int LOG2L = LOG2L_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [W-1:0]     in_sample,
  input  logic             shift_done,
  output logic             out_valid,
  output logic [OUT_W-1:0] out_sample,
  output logic [LOG2L-1:0] phase,
  output logic             busy,
  output logic             overrun
);
  state_t r_state, w_nstate;
  logic [W-1:0] r_prev, r_cur, r_pend, w_nprev, w_ncur, w_pdata, w_y;
  logic [LOG2L-1:0] r_phase, w_nphase;
  logic [OUT_W-1:0] r_out;
  logic r_full, r_ovr;
  logic w_busy, w_wdone, w_last, w_adv, w_wr, w_pfull, w_load, w_go;
  assign w_busy = r_state != IDLE;
  assign w_wdone = r_state == WAIT && shift_done;
  assign w_last = w_wdone && (&r_phase);
  assign w_adv = w_wdone && !(&r_phase);
  // A sample arriving with the final shift_done lands in pending and is consumed at once.
  assign w_wr = in_valid && w_busy;
  assign w_pfull = r_full || w_wr;
  assign w_pdata = in_valid ? in_sample : r_pend;
  assign w_load = (r_state == IDLE && in_valid) || (w_last && w_pfull);
  assign w_go = w_load || w_adv;
  assign w_nprev = w_load ? r_cur : r_prev;
  assign w_ncur = w_load ? w_pdata : r_cur;
  assign w_nphase = w_adv ? r_phase + LOG2L'(1) : (w_load || w_last) ? '0 : r_phase;
  assign w_nstate = w_go ? ISSUE : r_state == ISSUE ? WAIT : w_last ? IDLE : r_state;
`ifdef INTERP_LINEAR_EN
  interp_lerp #(.W(W), .LOG2L(LOG2L)) u_lerp (
    .i_prev(w_nprev),
    .i_cur (w_ncur),
    .i_k   (w_nphase),
    .o_y   (w_y)
  );
`else
  assign w_y = w_ncur;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_prev <= '0;
      r_cur <= '0;
      r_pend <= '0;
      r_full <= 1'b0;
      r_phase <= '0;
      r_out <= '0;
      r_ovr <= 1'b0;
    end else begin
      r_state <= w_nstate;
      r_prev <= w_nprev;
      r_cur <= w_ncur;
      r_pend <= w_wr ? in_sample : r_pend;
      r_full <= w_last ? 1'b0 : w_pfull;
      r_phase <= w_nphase;
      r_out <= w_go ? {w_y, {(OUT_W-W){1'b0}}} : r_out;
      r_ovr <= r_ovr || (w_wr && r_full);
    end
  end
  assign out_valid = r_state == ISSUE;
  assign out_sample = r_out;
  assign phase = r_phase;
  assign busy = w_busy;
  assign overrun = r_ovr;
endmodule

// File: tb/tb_interp_scheduler.sv
// tb_interp_scheduler: directed checks of grouping, pending buffer, overrun and reset abort.
module tb_interp_scheduler;
`ifdef INTERP_LINEAR_EN
  localparam bit LIN = 1'b1;
`else
  localparam bit LIN = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, shift_done = 1'b0;
  logic [15:0] in_sample = '0;
  logic out_valid, busy, overrun;
  logic [19:0] out_sample;
  logic [1:0] phase;
  int checks = 0, errors = 0;

  interp_scheduler dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_sample(in_sample),
    .shift_done(shift_done), .out_valid(out_valid), .out_sample(out_sample),
    .phase(phase), .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [15:0] s);
    in_valid = 1'b1;
    in_sample = s;
    @(negedge clk);
    in_valid = 1'b0;
    chk("latency", {31'b0, out_valid}, 1);
  endtask

  task automatic grp(input logic [19:0] l0, l1, l2, l3, z0, z1, z2, z3,
                     input int inj_ph, input int ninj, input logic [15:0] s1, s2,
                     input int stop_ph);
    logic [19:0] e [4];
    e[0] = LIN ? l0 : z0; e[1] = LIN ? l1 : z1;
    e[2] = LIN ? l2 : z2; e[3] = LIN ? l3 : z3;
    for (int k = 0; k < 4; k++) begin
      for (int n = 0; n < 40 && !out_valid; n++) @(negedge clk);
      chk($sformatf("out_valid k%0d", k), {31'b0, out_valid}, 1);
      chk($sformatf("out_sample k%0d", k), {12'b0, out_sample}, {12'b0, e[k]});
      chk($sformatf("phase k%0d", k), {30'b0, phase}, k);
      if (k == stop_ph) return;
      @(negedge clk);
      chk($sformatf("pulse k%0d", k), {31'b0, out_valid}, 0);
      for (int j = 0; j < 7; j++) begin
        in_valid = (k == inj_ph) && (j == 2 || (ninj > 1 && j == 4));
        in_sample = (j == 2) ? s1 : s2;
        @(negedge clk);
      end
      in_valid = 1'b0;
      shift_done = 1'b1;
      @(negedge clk);
      shift_done = 1'b0;
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst out_valid", {31'b0, out_valid}, 0);
    chk("rst out_sample", {12'b0, out_sample}, 0);
    chk("rst phase", {30'b0, phase}, 0);
    chk("rst busy", {31'b0, busy}, 0);
    chk("rst overrun", {31'b0, overrun}, 0);
    rst = 1'b0;
    @(negedge clk);
    // Ramp up from 0 to 0x1000.
    send(16'h1000);
    grp(20'h00000, 20'h04000, 20'h08000, 20'h0C000,
        20'h10000, 20'h10000, 20'h10000, 20'h10000, -1, 0, 0, 0, -1);
    chk("idle after g1", {31'b0, busy}, 0);
    // Negative slope.
    send(16'h0000);
    grp(20'h10000, 20'h0C000, 20'h08000, 20'h04000,
        20'h00000, 20'h00000, 20'h00000, 20'h00000, -1, 0, 0, 0, -1);
    send(16'h7FFF);
    grp(20'h00000, 20'h1FFF0, 20'h3FFF0, 20'h5FFF0,
        20'h7FFF0, 20'h7FFF0, 20'h7FFF0, 20'h7FFF0, -1, 0, 0, 0, -1);
    // Full-scale swing 0x7FFF -> 0x8000.
    send(16'h8000);
    grp(20'h7FFF0, 20'h3FFF0, 20'hFFFF0, 20'hBFFF0,
        20'h80000, 20'h80000, 20'h80000, 20'h80000, -1, 0, 0, 0, -1);
    chk("busy extremes", {31'b0, busy}, 0);
    // One sample arrives mid-group: chained without overrun.
    send(16'h1000);
    grp(20'h80000, 20'hA4000, 20'hC8000, 20'hEC000,
        20'h10000, 20'h10000, 20'h10000, 20'h10000, 1, 1, 16'h2000, 0, -1);
    chk("chain start", {31'b0, out_valid}, 1);
    chk("no overrun", {31'b0, overrun}, 0);
    grp(20'h10000, 20'h14000, 20'h18000, 20'h1C000,
        20'h20000, 20'h20000, 20'h20000, 20'h20000, -1, 0, 0, 0, -1);
    chk("idle after chain", {31'b0, busy}, 0);
    // Two samples mid-group: the newer one wins, overrun sticks.
    send(16'h3000);
    grp(20'h20000, 20'h24000, 20'h28000, 20'h2C000,
        20'h30000, 20'h30000, 20'h30000, 20'h30000, 1, 2, 16'h5000, 16'h4000, -1);
    chk("chain2 start", {31'b0, out_valid}, 1);
    chk("overrun set", {31'b0, overrun}, 1);
    grp(20'h30000, 20'h34000, 20'h38000, 20'h3C000,
        20'h40000, 20'h40000, 20'h40000, 20'h40000, -1, 0, 0, 0, -1);
    chk("overrun sticky", {31'b0, overrun}, 1);
    // Reset during WAIT at phase 2.
    send(16'h6000);
    grp(20'h40000, 20'h48000, 20'h50000, 20'h58000,
        20'h60000, 20'h60000, 20'h60000, 20'h60000, -1, 0, 0, 0, 2);
    repeat (3) @(negedge clk);
    chk("pre-abort busy", {31'b0, busy}, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("abort out_valid", {31'b0, out_valid}, 0);
    chk("abort out_sample", {12'b0, out_sample}, 0);
    chk("abort phase", {30'b0, phase}, 0);
    chk("abort busy", {31'b0, busy}, 0);
    chk("abort overrun", {31'b0, overrun}, 0);
    rst = 1'b0;
    @(negedge clk);
    send(16'h1000);
    grp(20'h00000, 20'h04000, 20'h08000, 20'h0C000,
        20'h10000, 20'h10000, 20'h10000, 20'h10000, -1, 0, 0, 0, -1);
    chk("final idle", {31'b0, busy}, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/interp_scheduler.md
Name: interp_scheduler

Overview:
Sequences the interpolation datapath between the PCM2706 receive interface and the PCM1702 serializer. Each input sample (data_rdy pulse) yields L output samples, issued one at a time to the serializer. Each output waits for the serializer's shift_done handshake before the next is issued. Sits between pcm2706_interface and pcm1702_interface_edges, and replaces the ad-hoc sample registers and interpolation counter in top.

Parameters:
W, 16, input sample width (signed two's complement).
OUT_W, 20, serializer word width; output is MSB-aligned (W bits, then OUT_W-W zero LSBs).
LOG2L, 2, log2 of upsampling factor L (L = 4 by default); legal range 1..4.

Ports:
clk  in  1  system clock.
rst  in  1  synchronous, active-high reset.
in_valid  in  1  one-cycle pulse: new input sample (from data_rdy).
in_sample  in  W  signed input sample, valid with in_valid.
shift_done  in  1  one-cycle pulse from serializer: current word fully shifted out.
out_valid  out  1  one-cycle pulse to serializer sample_rdy.
out_sample  out  OUT_W  signed output word, stable from out_valid until the next out_valid.
phase  out  LOG2L  index k of the current output within the group, 0..L-1.
busy  out  1  high in any state other than IDLE.
overrun  out  1  sticky: an input sample was lost; cleared only by rst.

Behaviour:
- Reset: state=IDLE; prev=cur=0; pending empty; phase=0; out_valid=0; out_sample=0; busy=0; overrun=0.
- States: IDLE, ISSUE, WAIT.
- IDLE, on in_valid: prev<=cur, cur<=in_sample, phase<=0, then go to ISSUE.
- ISSUE: out_valid=1 for exactly one cycle. out_sample is registered on entry to ISSUE. Next state is WAIT unconditionally.
- WAIT: on shift_done:
  - if phase<L-1: phase++, go to ISSUE;
  - if phase==L-1 and pending is full: prev<=cur, cur<=pending, clear pending, phase<=0, go to ISSUE;
  - otherwise go to IDLE with phase<=0.
- shift_done outside WAIT is ignored.
- Latency: in_valid at cycle t in IDLE gives out_valid at cycle t+1.
- Pending buffer (one-deep), for in_valid while busy:
  - empty: store the sample, set full;
  - full: overwrite with the newer sample, set overrun=1.
- Simultaneous events:
  - in_valid and the final shift_done in the same cycle: the new sample is written to pending first, then consumed by the same transition (it goes straight to ISSUE).
  - If pending was already full in that cycle, the older pending sample is the one lost, and overrun is set.
- Arithmetic (linear mode):
  - d = cur - prev, computed at W+1 bits signed.
  - y = prev + ((d * k) >>> LOG2L), with the product at W+1+LOG2L bits and an arithmetic (floor) shift.
  - y always lies between prev and cur, so it fits in W bits with no saturation needed.
  - out_sample = {y, (OUT_W-W)'b0}.
- ZOH mode: y = cur for every k.
- rst mid-group aborts immediately to the reset state. Pending contents are discarded.

Optional Feature:
INTERP_LINEAR_EN
- Defined: linear interpolation as above. The first group after reset ramps from 0.
- Undefined: zero-order hold (y = cur). The subtractor and multiplier are not synthesised, and prev is unused but kept so the port and state behaviour are identical.
- Handshake and timing are the same in both modes.

Decomposition:
- Package interp_pkg holds:
  - the state enum (IDLE, ISSUE, WAIT);
  - default constants W_DEF=16, OUT_W_DEF=20, LOG2L_DEF=2.
- Sub-module interp_lerp is combinational: prev, cur, k -> y. It is instantiated only under INTERP_LINEAR_EN; otherwise y=cur is assigned directly.
- FSM, pending buffer and phase counter stay in interp_scheduler.

Test Plan:
- Reset, then in_valid with in_sample=0x1000, shift_done returned 8 cycles after each out_valid -> 4 out_valid pulses, phase 0..3, then busy=0.
  - Linear: out_sample = 0x00000, 0x04000, 0x08000, 0x0C000.
  - ZOH: 0x10000 on all four.
- Second sample 0x0000 after 0x1000 (linear) -> out_sample = 0x10000, 0x0C000, 0x08000, 0x04000, exercising the negative d path.
- Extremes: prev=0x7FFF, cur=0x8000 (linear) -> y = 0x7FFF, 0x3FFF, 0xFFFF, 0xBFFF, with no overflow.
- in_valid mid-group (phase 1) -> no glitch in the current group; next group starts on the cycle after the 4th shift_done, with overrun=0.
- Two in_valids mid-group -> the second sample is used and overrun=1 stays set until rst.
- rst asserted in WAIT at phase 2 -> the next cycle shows all outputs at reset values. A later in_valid restarts at phase 0 with prev=0.
